// File: rtl/k_vector_loader.sv
// K-vector loader: packs narrow memory beats into full K rows and writes each
// row into the KSRAM through its write_enable/sram_ready handshake.
module k_vector_loader #(
    parameter int MAX_SEQ_LENGTH = 64,
    parameter int VEC_ELEMS      = 16,
    parameter int BEAT_ELEMS     = 4,
    parameter int NUM_VECTORS    = MAX_SEQ_LENGTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [$clog2(NUM_VECTORS):0]     seq_len,
    input  logic                             mem_valid,
    input  logic [8*BEAT_ELEMS-1:0]          mem_data,
    output logic                             mem_ready,
    output logic                             ksram_write_enable,
    input  logic                             ksram_sram_ready,
    output logic [8*VEC_ELEMS-1:0]           ksram_write_data,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(NUM_VECTORS):0]     vectors_loaded
);

    localparam int BEATS_PER_VEC = VEC_ELEMS / BEAT_ELEMS;
    localparam int BEAT_BITS     = 8 * BEAT_ELEMS;
    localparam int LEN_W         = $clog2(NUM_VECTORS) + 1;
    localparam int BEAT_W        = (BEATS_PER_VEC > 1) ? $clog2(BEATS_PER_VEC) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_VEC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PUSH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [LEN_W-1:0]       target;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [8*VEC_ELEMS-1:0] pack;

    // Oversized requests saturate at the KSRAM depth instead of wrapping.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(NUM_VECTORS)) begin
            return LEN_W'(NUM_VECTORS);
        end
        return len;
    endfunction

    assign ksram_write_data = pack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            target             <= '0;
            beat_cnt           <= '0;
            vectors_loaded     <= '0;
            pack               <= '0;
            mem_ready          <= 1'b0;
            ksram_write_enable <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target         <= clamp_len(seq_len);
                        vectors_loaded <= '0;
                        beat_cnt       <= '0;
                        busy           <= 1'b1;
                        if (clamp_len(seq_len) == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            mem_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (mem_valid && mem_ready) begin
                        for (int b = 0; b < BEATS_PER_VEC; b++) begin
                            if (beat_cnt == BEAT_W'(b)) begin
                                pack[b*BEAT_BITS +: BEAT_BITS] <= mem_data;
                            end
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt           <= '0;
                            state              <= PUSH;
                            mem_ready          <= 1'b0;
                            ksram_write_enable <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                PUSH: begin
                    // Row and enable hold until the KSRAM takes the row.
                    if (ksram_sram_ready) begin
                        vectors_loaded     <= vectors_loaded + LEN_W'(1);
                        ksram_write_enable <= 1'b0;
                        if ((vectors_loaded + LEN_W'(1)) == target) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            mem_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k_vector_loader.sv
// Randomized bench for k_vector_loader against a count-based behavioural model.
module tb_k_vector_loader;

    localparam int NV  = 8;
    localparam int BPV = 4;
    localparam logic [127:0] ROW0 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] ROW1 = 128'h1f1e1d1c1b1a19181716151413121110;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   seq_len = '0;
    logic         mem_valid = 1'b0;
    logic [31:0]  mem_data = '0;
    logic         mem_ready;
    logic         ksram_write_enable;
    logic         ksram_sram_ready = 1'b1;
    logic [127:0] ksram_write_data;
    logic         busy;
    logic         done;
    logic [3:0]   vectors_loaded;

    k_vector_loader #(
        .VEC_ELEMS(16),
        .BEAT_ELEMS(4),
        .NUM_VECTORS(NV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .seq_len(seq_len),
        .mem_valid(mem_valid),
        .mem_data(mem_data),
        .mem_ready(mem_ready),
        .ksram_write_enable(ksram_write_enable),
        .ksram_sram_ready(ksram_sram_ready),
        .ksram_write_data(ksram_write_data),
        .busy(busy),
        .done(done),
        .vectors_loaded(vectors_loaded)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a command is described only by how many beats were
    // taken and how many rows were written so far.
    bit           m_active = 1'b0;
    int           m_target = 0;
    int           m_beats  = 0;
    int           m_writes = 0;
    logic [127:0] m_row    = '0;

    function automatic bit e_ready();
        return m_active && (m_writes < m_target) && ((m_beats - m_writes*BPV) < BPV);
    endfunction
    function automatic bit e_wen();
        return m_active && (m_writes < m_target) && ((m_beats - m_writes*BPV) == BPV);
    endfunction
    function automatic bit e_done();
        return m_active && (m_writes == m_target);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_active <= 1'b0;
            m_target <= 0;
            m_beats  <= 0;
            m_writes <= 0;
            m_row    <= '0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_target <= (int'(seq_len) > NV) ? NV : int'(seq_len);
                m_beats  <= 0;
                m_writes <= 0;
            end
        end else if (e_done()) begin
            m_active <= 1'b0;
        end else begin
            if (e_ready() && mem_valid) begin
                m_row[(m_beats % BPV)*32 +: 32] <= mem_data;
                m_beats <= m_beats + 1;
            end
            if (e_wen() && ksram_sram_ready) begin
                m_writes <= m_writes + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            check("rst mem_ready", mem_ready, 0);
            check("rst write_enable", ksram_write_enable, 0);
            check("rst write_data", ksram_write_data, 0);
            check("rst busy", busy, 0);
            check("rst done", done, 0);
            check("rst vectors_loaded", vectors_loaded, 0);
        end else begin
            check("mem_ready", mem_ready, e_ready());
            check("write_enable", ksram_write_enable, e_wen());
            check("done", done, e_done());
            check("busy", busy, m_active);
            check("vectors_loaded", vectors_loaded, m_writes);
            if (e_wen()) check("write_data", ksram_write_data, m_row);
        end
    end

    // Stimulus state
    int           beat_k    = 0;
    int           wr_count  = 0;
    logic [127:0] wr_q[$];
    int           vmode     = 0;   // 0 always valid, 1 gap pattern, 2 random
    int           gidx      = 0;
    bit           rnd_ready = 1'b0;
    bit           rnd_data  = 1'b0;
    int           stall_left = 0;
    bit           gap_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic step();
        bit acc;
        acc = mem_valid && mem_ready;
        if (ksram_write_enable && ksram_sram_ready) begin
            wr_count++;
            wr_q.push_back(ksram_write_data);
        end
        @(posedge clock);
        #1;
        if (acc) beat_k++;
        if (rnd_data) mem_data = $urandom;
        else mem_data = {8'(4*beat_k+3), 8'(4*beat_k+2), 8'(4*beat_k+1), 8'(4*beat_k)};
        case (vmode)
            0: mem_valid = 1'b1;
            1: begin mem_valid = gap_pat[gidx % 7]; gidx++; end
            default: mem_valid = 1'($urandom_range(0, 1));
        endcase
        if (ksram_write_enable && stall_left > 0) begin
            ksram_sram_ready = 1'b0;
            stall_left--;
        end else begin
            ksram_sram_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic run_cmd(input int len, input int exp_writes, input int exp_lat,
                           input int poke_at, input string tag);
        int cyc;
        int w0;
        bit got;
        w0 = wr_count;
        wr_q.delete();
        beat_k  = 0;
        gidx    = 0;
        seq_len = 4'(len);
        start   = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (cyc < 3000 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (cyc == poke_at) begin
                    start   = 1'b1;
                    seq_len = 4'd5;
                end
                step();
                start = 1'b0;
                cyc++;
            end
        end
        check({tag, " done seen"}, got, 1);
        if (exp_lat >= 0) check({tag, " latency"}, cyc, exp_lat);
        check({tag, " writes"}, wr_count - w0, exp_writes);
        check({tag, " vectors_loaded"}, vectors_loaded, exp_writes);
        step();
        check({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();
        check("post-reset mem_ready", mem_ready, 0);
        check("post-reset write_enable", ksram_write_enable, 0);
        check("post-reset write_data", ksram_write_data, 0);
        check("post-reset vectors_loaded", vectors_loaded, 0);

        vmode = 0;
        run_cmd(2, 2, 11, -1, "b2b");
        check("b2b row0", wr_q.size() > 0 ? wr_q[0] : 128'hx, ROW0);
        check("b2b row1", wr_q.size() > 1 ? wr_q[1] : 128'hx, ROW1);

        stall_left = 3;
        run_cmd(1, 1, 9, -1, "backpressure");
        check("backpressure row0", wr_q.size() > 0 ? wr_q[0] : 128'hx, ROW0);

        vmode = 1;
        run_cmd(2, 2, -1, -1, "gaps");
        check("gaps row0", wr_q.size() > 0 ? wr_q[0] : 128'hx, ROW0);
        check("gaps row1", wr_q.size() > 1 ? wr_q[1] : 128'hx, ROW1);
        vmode = 0;

        run_cmd(0, 0, 1, -1, "len0");
        run_cmd(12, 8, 41, -1, "len12");
        run_cmd(8, 8, 41, -1, "len8");

        // Reset after two beats of the second row.
        begin
            int n;
            int w0;
            w0 = wr_count;
            beat_k  = 0;
            seq_len = 4'd2;
            start   = 1'b1;
            step();
            start = 1'b0;
            n = 0;
            while (beat_k < 6 && n < 200) begin
                step();
                n++;
            end
            check("midrow reached", beat_k, 6);
            reset = 1'b1;
            #1;
            check("midrow rst write_enable", ksram_write_enable, 0);
            check("midrow rst mem_ready", mem_ready, 0);
            check("midrow rst busy", busy, 0);
            check("midrow rst data", ksram_write_data, 0);
            check("midrow rst vectors_loaded", vectors_loaded, 0);
            step();
            step();
            reset = 1'b0;
            step();
            check("midrow writes", wr_count - w0, 1);
        end
        run_cmd(1, 1, 6, -1, "after reset");
        check("after reset row0", wr_q.size() > 0 ? wr_q[0] : 128'hx, ROW0);

        run_cmd(2, 2, 11, 3, "start while busy");
        check("start while busy row1", wr_q.size() > 1 ? wr_q[1] : 128'hx, ROW1);

        vmode     = 2;
        rnd_ready = 1'b1;
        rnd_data  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int len;
            len = $urandom_range(0, 15);
            run_cmd(len, (len > NV) ? NV : len, -1, -1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
